// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 message padder.
package md5_pkg;

  // MD5 initial chaining values (little-endian words as defined by RFC 1321)
  localparam logic [31:0] MD5_A0 = 32'h67452301;
  localparam logic [31:0] MD5_B0 = 32'hefcdab89;
  localparam logic [31:0] MD5_C0 = 32'h98badcfe;
  localparam logic [31:0] MD5_D0 = 32'h10325476;

  // One MD5 block and its layout
  localparam int unsigned BLOCK_W    = 512;
  localparam int unsigned LEN_OFFSET = 56;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;

  // Padder control states
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DROP    = 2'd2
  } pad_state_e;

  // Byte index of the high length byte (bit length never exceeds 16 bits here)
  function automatic logic [5:0] len_hi_idx();
    return 6'(LEN_OFFSET + 1);
  endfunction

endpackage

// File: rtl/md5_msg_pad_if.sv
// Byte-stream handshake between a message source and the MD5 padder.
interface md5_msg_pad_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/md5_byte_lane_wr.sv
// Combinational byte-lane writer: replaces byte idx of a 512-bit block
// (byte 0 at the MSB end) with byte_in when we is set.
module md5_byte_lane_wr
  import md5_pkg::*;
(
  input  logic [BLOCK_W-1:0] vec_in,
  input  logic [5:0]         idx,
  input  logic [7:0]         byte_in,
  input  logic               we,
  output logic [BLOCK_W-1:0] vec_out
);

  // Select the addressed lane; every other lane passes through unchanged
  always_comb begin
    vec_out = vec_in;
    for (int i = 0; i < 64; i++) begin
      if (we && (idx == 6'(i))) begin
        vec_out[BLOCK_W-1-8*i -: 8] = byte_in;
      end else begin
        vec_out[BLOCK_W-1-8*i -: 8] = vec_in[BLOCK_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/md5_msg_pad.sv
// Packs a byte-stream message into one padded MD5 block and hands it, with
// the initial vector, to the first stage of the hash pipeline.
module md5_msg_pad
  import md5_pkg::*;
#(
  parameter int unsigned MAX_LEN = 55,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  md5_msg_pad_if.slave       s_if,
  output logic [31:0]        a_out,
  output logic [31:0]        b_out,
  output logic [31:0]        c_out,
  output logic [31:0]        d_out,
  output logic [BLOCK_W-1:0] m_out,
  output logic               valid_out,
  output logic               overflow,
  output logic [CNT_W-1:0]   msg_count
);

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);

  pad_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic               accept_s;
  logic [5:0]         cnt_plus1_s;
  logic [15:0]        len_bits_s;
  logic [BLOCK_W-1:0] buf_data_s;
  logic [BLOCK_W-1:0] buf_pad_s;
  logic [BLOCK_W-1:0] buf_lenlo_s;
  logic [BLOCK_W-1:0] buf_last_s;

  assign accept_s    = s_if.s_valid && ready_q;
  assign cnt_plus1_s = cnt_q + 6'd1;
  // Message length in bits: (cnt+1)*8, at most 440 so 16 bits suffice
  assign len_bits_s  = {7'd0, cnt_plus1_s, 3'd0};

  // Data byte lands at the current fill position
  md5_byte_lane_wr u_wr_data (
    .vec_in  (buf_q),
    .idx     (cnt_q),
    .byte_in (s_if.s_data),
    .we      (1'b1),
    .vec_out (buf_data_s)
  );

  // On the final byte, the 0x80 marker follows immediately after it
  md5_byte_lane_wr u_wr_pad (
    .vec_in  (buf_data_s),
    .idx     (cnt_plus1_s),
    .byte_in (PAD_BYTE),
    .we      (s_if.s_last),
    .vec_out (buf_pad_s)
  );

  // Low byte of the little-endian bit-length field
  md5_byte_lane_wr u_wr_len_lo (
    .vec_in  (buf_pad_s),
    .idx     (6'(LEN_OFFSET)),
    .byte_in (len_bits_s[7:0]),
    .we      (s_if.s_last),
    .vec_out (buf_lenlo_s)
  );

  // High byte of the bit-length field; bytes 58..63 stay zero
  md5_byte_lane_wr u_wr_len_hi (
    .vec_in  (buf_lenlo_s),
    .idx     (len_hi_idx()),
    .byte_in (len_bits_s[15:8]),
    .we      (s_if.s_last),
    .vec_out (buf_last_s)
  );

  // Next-state and datapath update for collect / emit / drop
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    ovf_d     = 1'b0;
    msg_cnt_d = msg_cnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          if (cnt_q >= MAX_LEN_C) begin
            // Message is one byte too long: drop it and discard the rest
            ovf_d = 1'b1;
            buf_d = '0;
            cnt_d = 6'd0;
            if (s_if.s_last) begin
              state_d = ST_COLLECT;
            end else begin
              state_d = ST_DROP;
            end
          end else if (s_if.s_last) begin
            buf_d   = buf_last_s;
            cnt_d   = cnt_plus1_s;
            state_d = ST_EMIT;
          end else begin
            buf_d = buf_data_s;
            cnt_d = cnt_plus1_s;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        if (en) begin
          // First pipeline stage captures the block on this edge
          buf_d     = '0;
          cnt_d     = 6'd0;
          msg_cnt_d = msg_cnt_q + CNT_W'(1);
          state_d   = ST_COLLECT;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DROP: begin
        if (accept_s && s_if.s_last) begin
          buf_d   = '0;
          cnt_d   = 6'd0;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = 6'd0;
        state_d = ST_COLLECT;
      end
    endcase
    ready_d = (state_d != ST_EMIT);
    valid_d = (state_d == ST_EMIT);
  end

  // State, buffer and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_COLLECT;
      cnt_q     <= 6'd0;
      buf_q     <= '0;
      ovf_q     <= 1'b0;
      msg_cnt_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      ovf_q     <= ovf_d;
      msg_cnt_q <= msg_cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end

  assign s_if.s_ready = ready_q;
  assign m_out        = buf_q;
  assign valid_out    = valid_q;
  assign overflow     = ovf_q;
  assign msg_count    = msg_cnt_q;
  assign a_out        = MD5_A0;
  assign b_out        = MD5_B0;
  assign c_out        = MD5_C0;
  assign d_out        = MD5_D0;

endmodule
